// File: rtl/info_frame_buffer.sv
// Double-buffered HDMI InfoFrame generator: stage PB1..PB_LENGTH, commit, publish on frame_boundary.
// Latency: PENDING LENGTH+1 edges after commit; publish on first frame_boundary seen in PENDING.
module info_frame_buffer #(
    parameter logic [6:0] TYPE    = 7'd2,
    parameter logic [7:0] VERSION = 8'd2,
    parameter logic [4:0] LENGTH  = 5'd13
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        commit,
    input  logic        frame_boundary,
    output logic [23:0] header,
    output logic [55:0] sub [3:0],
    output logic        valid,
    output logic        busy
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SUM     = 2'd1;
    localparam logic [1:0] PENDING = 2'd2;
    localparam logic [7:0] HDR_SUM = {1'b1, TYPE} + VERSION + {3'b000, LENGTH};

    logic [1:0] state;
    logic       commit_q;
    logic [4:0] idx;
    logic [7:0] acc;
    logic [7:0] cksum;
    logic [7:0] active_ck;
    logic [7:0] staging [1:27];
    logic [7:0] shadow  [1:27];
    logic [7:0] active  [1:27];
    logic [7:0] pb      [0:27];

    assign header = {{3'b000, LENGTH}, VERSION, {1'b1, TYPE}};
    assign busy   = (state != IDLE) | commit_q;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            for (int j = 1; j <= 27; j++) staging[j] <= 8'h00;
        end else if (wr_en && (wr_addr != 5'd0) && (wr_addr <= LENGTH)) begin
            staging[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            commit_q  <= 1'b0;
            idx       <= 5'd0;
            acc       <= 8'h00;
            cksum     <= 8'h00;
            active_ck <= 8'h00;
            valid     <= 1'b0;
            for (int j = 1; j <= 27; j++) begin
                shadow[j] <= 8'h00;
                active[j] <= 8'h00;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (commit) begin
                        shadow <= staging;
                        acc    <= HDR_SUM;
                        idx    <= 5'd1;
                        state  <= SUM;
                    end
                end
                SUM: begin
                    acc <= acc + shadow[idx];
                    idx <= idx + 5'd1;
                    if (commit) commit_q <= 1'b1;
                    if (idx == LENGTH) begin
                        cksum <= 8'h00 - (acc + shadow[idx]);
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (frame_boundary) begin
                        active    <= shadow;
                        active_ck <= cksum;
                        valid     <= 1'b1;
                        // A commit arriving with the boundary is folded into the reload right away.
                        if (commit_q || commit) begin
                            shadow   <= staging;
                            acc      <= HDR_SUM;
                            idx      <= 5'd1;
                            commit_q <= 1'b0;
                            state    <= SUM;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (commit) begin
                        commit_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bytes above LENGTH are forced to zero regardless of buffer contents.
    always_comb begin
        pb[0] = active_ck;
        for (int j = 1; j <= 27; j++) begin
            pb[j] = (j <= int'(LENGTH)) ? active[j] : 8'h00;
        end
        for (int i = 0; i < 4; i++) begin
            sub[i] = '0;
            for (int k = 0; k < 7; k++) begin
                sub[i][8*k +: 8] = pb[7*i + k];
            end
        end
    end
endmodule

// File: tb/tb_info_frame_buffer.sv
// Bench for info_frame_buffer: default instance plus a TYPE=4/VERSION=1/LENGTH=10 instance.
module tb_info_frame_buffer;
    typedef logic [223:0] pkt_t;
    typedef struct {
        logic [4:0]  a0;
        logic [7:0]  d0;
        logic [4:0]  a1;
        logic [7:0]  d1;
        logic [55:0] s0;
        logic [55:0] s1;
    } vec_t;

    logic        clk_pixel = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        commit = 1'b0;
    logic        frame_boundary = 1'b0;
    logic [23:0] header, header2;
    logic [55:0] sub  [3:0];
    logic [55:0] sub2 [3:0];
    logic        valid, busy, valid2, busy2;

    always #5 clk_pixel = ~clk_pixel;

    info_frame_buffer dut (
        .clk_pixel(clk_pixel), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .frame_boundary(frame_boundary),
        .header(header), .sub(sub), .valid(valid), .busy(busy)
    );

    info_frame_buffer #(.TYPE(7'd4), .VERSION(8'd1), .LENGTH(5'd10)) dut2 (
        .clk_pixel(clk_pixel), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .frame_boundary(frame_boundary),
        .header(header2), .sub(sub2), .valid(valid2), .busy(busy2)
    );

    pkt_t       q1 [$];
    pkt_t       q2 [$];
    pkt_t       last1;
    logic [7:0] m1 [1:27];
    logic [7:0] m2 [1:27];
    vec_t       tbl [4];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference packet: every byte above len is zero, PB0 makes the total wrap to zero.
    function automatic pkt_t model_pkt(input logic [7:0] stg [1:27], input int len,
                                       input logic [7:0] hsum);
        pkt_t       p;
        logic [7:0] acc;
        logic [7:0] b;
        p   = '0;
        acc = hsum;
        for (int j = 1; j <= 27; j++) begin
            b = (j <= len) ? stg[j] : 8'h00;
            acc = acc + b;
            p[8*j +: 8] = b;
        end
        p[7:0] = 8'h00 - acc;
        return p;
    endfunction

    function automatic pkt_t flat1();
        return {sub[3], sub[2], sub[1], sub[0]};
    endfunction

    function automatic pkt_t flat2();
        return {sub2[3], sub2[2], sub2[1], sub2[0]};
    endfunction

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        commit = 1'b0;
        frame_boundary = 1'b0;
        #1;
        q1.delete();
        q2.delete();
        last1 = '0;
        for (int j = 1; j <= 27; j++) begin
            m1[j] = 8'h00;
            m2[j] = 8'h00;
        end
    endtask

    task automatic release_reset();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic model_write(input logic [4:0] a, input logic [7:0] d);
        if (a >= 5'd1 && a <= 5'd13) m1[a] = d;
        if (a >= 5'd1 && a <= 5'd10) m2[a] = d;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        model_write(a, d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic commit_start(input bit push1, input bit push2);
        commit = 1'b1;
        if (push1) q1.push_back(model_pkt(m1, 13, 8'h91));
        if (push2) q2.push_back(model_pkt(m2, 10, 8'h8F));
        tick();
        commit = 1'b0;
    endtask

    task automatic boundary_pulse();
        frame_boundary = 1'b1;
        tick();
        frame_boundary = 1'b0;
    endtask

    task automatic check_pub1(input string name);
        if (q1.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got publish want none queued", name);
        end else begin
            last1 = q1.pop_front();
            chk(name, flat1(), last1);
        end
        chk({name, "_valid"}, valid, 1);
    endtask

    initial begin
        tbl[0] = '{5'd2,  8'h08, 5'd4,  8'h04, 56'h00000400080063, 56'h0};
        tbl[1] = '{5'd0,  8'hFF, 5'd14, 8'h55, 56'h00000400080063, 56'h0};
        tbl[2] = '{5'd7,  8'h10, 5'd13, 8'h20, 56'h00000400080033, 56'h20000000000010};
        tbl[3] = '{5'd1,  8'hFF, 5'd2,  8'h01, 56'h0000040001FF3B, 56'h20000000000010};

        assert_reset();
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sub", flat1(), '0);
        chk("rst_header", header, 24'h0D0282);
        chk("rst_header2", header2, 24'h0A0184);
        release_reset();
        chk("idle_busy", busy, 0);

        for (int v = 0; v < 4; v++) begin
            wr(tbl[v].a0, tbl[v].d0);
            wr(tbl[v].a1, tbl[v].d1);
            commit_start(1, 0);
            chk($sformatf("v%0d_busy_sum", v), busy, 1);
            repeat (13) tick();
            chk($sformatf("v%0d_busy_pend", v), busy, 1);
            boundary_pulse();
            check_pub1($sformatf("v%0d_pkt", v));
            chk($sformatf("v%0d_sub0", v), sub[0], tbl[v].s0);
            chk($sformatf("v%0d_sub1", v), sub[1], tbl[v].s1);
            chk($sformatf("v%0d_busy_done", v), busy, 0);
        end

        // Boundary held through SUM (including the finishing edge) must not swap.
        wr(5'd5, 8'h77);
        commit = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 8'h99;
        q1.push_back(model_pkt(m1, 13, 8'h91));
        model_write(5'd6, 8'h99);
        tick();
        commit = 1'b0;
        wr_en = 1'b0;
        frame_boundary = 1'b1;
        for (int c = 0; c < 13; c++) begin
            tick();
            chk($sformatf("sum_hold_%0d", c), flat1(), last1);
        end
        tick();
        frame_boundary = 1'b0;
        check_pub1("sum_exact_swap");
        boundary_pulse();
        chk("idle_boundary", flat1(), last1);

        // Queued commit snapshots staging at reload time.
        assert_reset();
        release_reset();
        wr(5'd2, 8'h08);
        wr(5'd4, 8'h04);
        commit_start(1, 0);
        wr(5'd4, 8'h05);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (11) tick();
        chk("q_busy_pend", busy, 1);
        q1.push_back(model_pkt(m1, 13, 8'h91));
        boundary_pulse();
        check_pub1("q_first");
        chk("q_first_sub0", sub[0], 56'h00000400080063);
        chk("q_busy_reload", busy, 1);
        repeat (13) tick();
        commit = 1'b1;
        q1.push_back(model_pkt(m1, 13, 8'h91));
        boundary_pulse();
        commit = 1'b0;
        check_pub1("q_second");
        chk("q_second_sub0", sub[0], 56'h00000500080062);
        chk("cb_busy", busy, 1);
        repeat (13) tick();
        boundary_pulse();
        check_pub1("cb_third");
        chk("cb_busy_done", busy, 0);

        // Reset while PENDING discards everything.
        commit_start(0, 0);
        repeat (13) tick();
        assert_reset();
        chk("rp_sub", flat1(), '0);
        chk("rp_valid", valid, 0);
        chk("rp_busy", busy, 0);
        release_reset();
        boundary_pulse();
        chk("rp_after_sub", flat1(), '0);
        chk("rp_after_valid", valid, 0);

        // Non-default parameters, out-of-range write above LENGTH.
        wr(5'd1, 8'h01);
        wr(5'd11, 8'hFF);
        commit_start(0, 1);
        repeat (10) tick();
        boundary_pulse();
        if (q2.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL p2_pkt: got publish want none queued");
        end else begin
            chk("p2_pkt", flat2(), q2.pop_front());
        end
        chk("p2_sub0", sub2[0], 56'h00000000000170);
        chk("p2_pb11", sub2[1][39:32], 8'h00);
        chk("p2_valid", valid2, 1);
        chk("p2_busy", busy2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
